// File: rtl/bpu_pkg.sv
// bpu_pkg: encodings shared by the branch predictor top and its update sequencer.
// Holds the update FSM state encoding, branch kind constants and the bit
// offsets of the fields inside the packed 128-bit update record.
package bpu_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } upd_state_e;

    typedef enum logic [2:0] {
        NOT_JUMP      = 3'd0,
        DIRECT_JUMP   = 3'd1,
        JUMP          = 3'd2,
        CALL          = 3'd3,
        RET           = 3'd4,
        INDIRECT_JUMP = 3'd5,
        OTHER_JUMP    = 3'd6
    } br_kind_e;

    // Update record layout, LSB first; fills exactly 128 bits.
    localparam int REC_PC_LSB          = 0;
    localparam int REC_NPC_LSB         = 32;
    localparam int REC_RET_PC_LSB      = 64;
    localparam int REC_KIND_LSB        = 96;
    localparam int REC_TAKEN_BIT       = 99;
    localparam int REC_MIS_BIT         = 100;
    localparam int REC_BH_LSB          = 101;
    localparam int REC_BH_W            = 16;
    localparam int REC_CHOICE_REAL_BIT = 117;
    localparam int REC_CHOICE_PDC_BIT  = 118;
    localparam int REC_PDCH_LSB        = 119;
    localparam int REC_PDCH_W          = 9;

endpackage

// File: rtl/bpu_upd_fifo.sv
// bpu_upd_fifo: synchronous FIFO buffering predictor update records.
// Ports: clk/rstn (sync, active-low); push/push_rec write the tail when not
// full; pop advances the head when not empty; head is the oldest record;
// full/empty flags; count is the number of stored records.
module bpu_upd_fifo #(
    parameter int REC_W = 128,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [REC_W-1:0] push_rec,
    input  logic             pop,
    output logic [REC_W-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = wptr_q == rptr_q;
    assign count = wptr_q - rptr_q;
    assign head  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wptr_q[AW-1:0]] <= push_rec;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push && !full) wptr_q <= wptr_q + 1'b1;
            if (pop && !empty) rptr_q <= rptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/bpu_update_ctrl.sv
// bpu_update_ctrl: sequencer for the branch predictor's single update port.
// Ports: clk/rstn (sync, active-low); ex_valid/ex_rec/ex_ready accept
// resolved-branch records from EX; flush_req requests a table re-clear;
// upd_stall holds issue; upd_en/upd_rec drive the predictor update;
// init_we/init_idx sweep-clear all tables; busy flags INIT/DRAIN;
// occupancy is the buffered record count; upd_cnt counts issued updates.
module bpu_update_ctrl
    import bpu_pkg::*;
#(
    parameter int K_WIDTH = 14,
    parameter int REC_W   = 128,
    parameter int DEPTH   = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               ex_valid,
    input  logic [REC_W-1:0]   ex_rec,
    output logic               ex_ready,
    input  logic               flush_req,
    input  logic               upd_stall,
    output logic               upd_en,
    output logic [REC_W-1:0]   upd_rec,
    output logic               init_we,
    output logic [K_WIDTH-1:0] init_idx,
    output logic               busy,
    output logic [CW-1:0]      occupancy,
    output logic [31:0]        upd_cnt
);

    upd_state_e         state_q;
    logic [K_WIDTH-1:0] idx_q;
    logic [31:0]        cnt_q;
    logic               full;
    logic               empty;

    // Readiness ignores the same-cycle pop: a full FIFO never pushes through.
    assign ex_ready = !full && state_q != DRAIN;
    assign upd_en   = state_q != INIT && !empty && !upd_stall;
    assign init_we  = state_q == INIT;
    assign init_idx = idx_q;
    assign busy     = state_q != RUN;
    assign upd_cnt  = cnt_q;

    bpu_upd_fifo #(.REC_W(REC_W), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (ex_valid && ex_ready),
        .push_rec (ex_rec),
        .pop      (upd_en),
        .head     (upd_rec),
        .full     (full),
        .empty    (empty),
        .count    (occupancy)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= INIT;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (upd_en) cnt_q <= cnt_q + 32'd1;
            case (state_q)
                INIT: begin
                    // A flush mid-sweep, even on the last index, restarts at 0.
                    idx_q <= (flush_req || &idx_q) ? '0 : idx_q + 1'b1;
                    if (!flush_req && &idx_q) state_q <= RUN;
                end
                RUN: if (flush_req) state_q <= DRAIN;
                DRAIN: if (empty) begin
                    state_q <= INIT;
                    idx_q   <= '0;
                end
                default: state_q <= INIT;
            endcase
        end
    end

endmodule
